alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_if.sv | 30 +++
 rtl/alu_issue_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Handshake and operand bus between decode, the ALU issue stage and execute.
// 'slave' is the issue stage's view; 'master' is the surrounding pipeline.
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic             is_branch;
    logic             illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, is_branch, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctrl, is_branch, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes operands/ALU op and registers them toward execute.
// Optional macro ALU_ISSUE_SKID_EN adds a one-entry skid buffer with registered in_ready.
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
        logic             br;
        logic             ill;
    } issue_t;

    function automatic issue_t decode(input logic [31:0]      ins,
                                      input logic [WIDTH-1:0] pc_v,
                                      input logic [WIDTH-1:0] rs1,
                                      input logic [WIDTH-1:0] rs2);
        issue_t           d;
        issue_t           ill_d;
        logic [6:0]       f7;
        logic [2:0]       f3;
        logic [WIDTH-1:0] imm_i;
        logic [WIDTH-1:0] imm_s;
        logic [WIDTH-1:0] imm_u;
        logic [WIDTH-1:0] shamt;
        d     = '0;
        ill_d = '0;
        ill_d.ill = 1'b1;
        f7    = ins[31:25];
        f3    = ins[14:12];
        imm_i = WIDTH'($signed(ins[31:20]));
        imm_s = WIDTH'($signed({ins[31:25], ins[11:7]}));
        imm_u = WIDTH'($signed({ins[31:12], 12'h000}));
        shamt = WIDTH'(ins[24:20]);
        case (ins[6:0])
            7'b0110011: begin
                d.a = rs1;
                d.b = rs2;
                if (f7 == 7'b0000000) begin
                    d.ctrl = {1'b0, f3};
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.ctrl = 4'b1010;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.ctrl = 4'b1011;
                end else begin
                    d.ill = 1'b1;
                end
            end
            7'b0010011: begin
                d.a = rs1;
                case (f3)
                    3'b001: begin
                        d.b    = shamt;
                        d.ctrl = 4'b0001;
                        d.ill  = (f7 != 7'b0000000);
                    end
                    3'b101: begin
                        d.b    = shamt;
                        d.ctrl = ins[30] ? 4'b1011 : 4'b0101;
                        d.ill  = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                    default: begin
                        d.b    = imm_i;
                        d.ctrl = {1'b0, f3};
                    end
                endcase
            end
            7'b1100011: begin
                d.a  = rs1;
                d.b  = rs2;
                d.br = 1'b1;
                case (f3)
                    3'b000:  d.ctrl = 4'b1000;
                    3'b001:  d.ctrl = 4'b1001;
                    3'b100:  d.ctrl = 4'b1100;
                    3'b101:  d.ctrl = 4'b1101;
                    3'b110:  d.ctrl = 4'b1110;
                    3'b111:  d.ctrl = 4'b1111;
                    default: d.ill  = 1'b1;
                endcase
            end
            7'b0000011: begin
                d.a = rs1;
                d.b = imm_i;
            end
            7'b0100011: begin
                d.a = rs1;
                d.b = imm_s;
            end
            7'b0110111: begin
                d.b = imm_u;
            end
            7'b0010111: begin
                d.a = pc_v;
                d.b = imm_u;
            end
            7'b1101111, 7'b1100111: begin
                d.a = pc_v;
                d.b = WIDTH'(4);
            end
            default: d.ill = 1'b1;
        endcase
        // Undecodable words leave the stage as a zeroed ADD with only the illegal flag set.
        return d.ill ? ill_d : d;
    endfunction

    issue_t dec_s;
    issue_t out_r;
    logic   out_valid_r;

    // Decode the instruction currently presented by the decode stage.
    always_comb begin
        dec_s = decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
    end

    assign bus.out_valid = out_valid_r;
    assign bus.alu_a     = out_r.a;
    assign bus.alu_b     = out_r.b;
    assign bus.alu_ctrl  = out_r.ctrl;
    assign bus.is_branch = out_r.br;
    assign bus.illegal   = out_r.ill;

`ifdef ALU_ISSUE_SKID_EN
    issue_t skid_r;
    logic   skid_valid_r;
    logic   in_ready_r;
    logic   in_fire_s;
    logic   out_free_s;

    assign bus.in_ready = in_ready_r;
    assign in_fire_s    = bus.in_valid && in_ready_r;
    assign out_free_s   = !out_valid_r || bus.out_ready;

    // Output register plus skid entry; skid drains ahead of new input to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r        <= '0;
            out_valid_r  <= 1'b0;
            skid_r       <= '0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (bus.flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else if (in_fire_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
`else
    logic in_ready_s;

    assign in_ready_s   = !out_valid_r || bus.out_ready;
    assign bus.in_ready = in_ready_s;

    // Single output register: load on accept, drop valid once consumed, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (bus.in_valid && in_ready_s) begin
            out_r       <= dec_s;
            out_valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
`endif

endmodule
